// File: rtl/sw_loop_ctrl.sv
// sw_loop_ctrl: front-end loop controller for the Smith-Waterman PE chain.
// Pass 0 streams host target symbols into the chain head with zero scores.
// Middle passes forward the segment returning from the recirculation register.
// The final pass is not forwarded. Its running max values are reduced to one score.
//
// Handshake semantics (all streams): a beat moves on a rising clk edge when
// its valid is high (and, for the host stream, host_ready is high). Valid must
// stay high for the whole T_LEN-beat stream, because a valid drop mid-stream
// is read downstream as end of stream. Such a drop is flagged on err.
module sw_loop_ctrl #(
  parameter int T_LEN    = 128,
  parameter int NUM_PASS = 4,
  parameter int DW       = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    host_t,
  input  logic          host_valid,
  output logic          host_ready,
  input  logic          sr_valid,
  input  logic [1:0]    sr_t,
  input  logic [DW-1:0] sr_max,
  input  logic [DW-1:0] sr_v,
  input  logic [DW-1:0] sr_f,
  output logic          pe_valid,
  output logic [1:0]    pe_t,
  output logic [DW-1:0] pe_max,
  output logic [DW-1:0] pe_v,
  output logic [DW-1:0] pe_f,
  output logic [7:0]    pass_idx,
  output logic [DW-1:0] score,
  output logic          done,
  output logic          err,
  output logic [2:0]    dbg_state
);

  localparam int CW = $clog2(T_LEN + 1);
  localparam logic [CW-1:0] LAST_BEAT  = CW'(T_LEN - 1);
  localparam logic [7:0]    FINAL_PASS = 8'(NUM_PASS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FEED  = 3'd1,
    S_WAIT  = 3'd2,
    S_LOOP  = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t        state_q;
  logic [CW-1:0] beat_cnt_q;
  logic [7:0]    pass_idx_q;
  logic [DW-1:0] score_q;
  logic          err_q;
  logic          done_q;
  logic          sr_valid_prev_q;
  logic          pe_valid_q;
  logic [1:0]    pe_t_q;
  logic [DW-1:0] pe_max_q;
  logic [DW-1:0] pe_v_q;
  logic [DW-1:0] pe_f_q;

  logic          last_beat;
  logic          seg_drain;
  logic [DW-1:0] drain_max_d;

  // Beat bookkeeping shared by the segment states: last beat of a segment,
  // whether the current segment is the reduced one, and the running max.
  always_comb begin
    last_beat   = 1'b0;
    seg_drain   = 1'b0;
    drain_max_d = score_q;
    last_beat   = (beat_cnt_q == LAST_BEAT);
    seg_drain   = (state_q == S_DRAIN) ||
                  ((state_q == S_WAIT) && (pass_idx_q == FINAL_PASS));
    if (sr_max > score_q) begin
      drain_max_d = sr_max;
    end
  end

  // Main FSM. All outputs are registered here, and pe_* default to zero
  // whenever no beat is forwarded in a cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      beat_cnt_q      <= '0;
      pass_idx_q      <= '0;
      score_q         <= '0;
      err_q           <= 1'b0;
      done_q          <= 1'b0;
      sr_valid_prev_q <= 1'b0;
      pe_valid_q      <= 1'b0;
      pe_t_q          <= '0;
      pe_max_q        <= '0;
      pe_v_q          <= '0;
      pe_f_q          <= '0;
    end else begin
      sr_valid_prev_q <= sr_valid;
      done_q          <= 1'b0;
      pe_valid_q      <= 1'b0;
      pe_t_q          <= '0;
      pe_max_q        <= '0;
      pe_v_q          <= '0;
      pe_f_q          <= '0;

      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            score_q    <= '0;
            err_q      <= 1'b0;
            pass_idx_q <= '0;
            beat_cnt_q <= '0;
            state_q    <= S_FEED;
          end
        end

        S_FEED: begin
          if (host_valid) begin
            pe_valid_q <= 1'b1;
            pe_t_q     <= host_t;
            if (last_beat) begin
              beat_cnt_q <= '0;
              pass_idx_q <= pass_idx_q + 8'd1;
              state_q    <= S_WAIT;
            end else begin
              beat_cnt_q <= beat_cnt_q + CW'(1);
            end
          end else if (beat_cnt_q != '0) begin
            // A mid-stream bubble would end the stream early downstream.
            err_q <= 1'b1;
          end
          // The recirculation register should be silent during pass 0.
          if (sr_valid && !sr_valid_prev_q) begin
            err_q <= 1'b1;
          end
        end

        // WAIT handles the first beat of a segment exactly like LOOP/DRAIN,
        // so no beat is lost on the transition.
        S_WAIT, S_LOOP, S_DRAIN: begin
          if (sr_valid) begin
            if (seg_drain) begin
              score_q <= drain_max_d;
              if (last_beat) begin
                beat_cnt_q <= '0;
                done_q     <= 1'b1;
                state_q    <= S_DONE;
              end else begin
                beat_cnt_q <= beat_cnt_q + CW'(1);
                state_q    <= S_DRAIN;
              end
            end else begin
              pe_valid_q <= 1'b1;
              pe_t_q     <= sr_t;
              pe_max_q   <= sr_max;
              pe_v_q     <= sr_v;
              pe_f_q     <= sr_f;
              if (last_beat) begin
                beat_cnt_q <= '0;
                pass_idx_q <= pass_idx_q + 8'd1;
                state_q    <= S_WAIT;
              end else begin
                beat_cnt_q <= beat_cnt_q + CW'(1);
                state_q    <= S_LOOP;
              end
            end
          end else if (state_q == S_LOOP) begin
            // Short segment: flag it and keep waiting for the remaining beats.
            err_q <= 1'b1;
          end
        end

        S_DONE: begin
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign host_ready = (state_q == S_FEED);
  assign pe_valid   = pe_valid_q;
  assign pe_t       = pe_t_q;
  assign pe_max     = pe_max_q;
  assign pe_v       = pe_v_q;
  assign pe_f       = pe_f_q;
  assign pass_idx   = pass_idx_q;
  assign score      = score_q;
  assign done       = done_q;
  assign err        = err_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_sw_loop_ctrl.sv
// Bench for sw_loop_ctrl: one instance with NUM_PASS=1 and one with NUM_PASS=3,
// both with T_LEN=4. They share the data inputs and have separate start strobes.
// The expected behaviour is modelled per pass. Pass 0 echoes the host symbols
// with zero scores, middle passes echo the segment one cycle later, and the
// final pass yields the max of its sr_max values.
module tb_sw_loop_ctrl;
  localparam int T_LEN = 4;
  localparam int DW    = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start1 = 1'b0, start3 = 1'b0;
  logic [1:0]    host_t = '0;
  logic          host_valid = 1'b0;
  logic          sr_valid = 1'b0;
  logic [1:0]    sr_t = '0;
  logic [DW-1:0] sr_max = '0, sr_v = '0, sr_f = '0;

  logic          d1_host_ready, d1_pe_valid, d1_done, d1_err;
  logic [1:0]    d1_pe_t;
  logic [DW-1:0] d1_pe_max, d1_pe_v, d1_pe_f, d1_score;
  logic [7:0]    d1_pass_idx;
  logic [2:0]    d1_dbg;
  logic          d3_host_ready, d3_pe_valid, d3_done, d3_err;
  logic [1:0]    d3_pe_t;
  logic [DW-1:0] d3_pe_max, d3_pe_v, d3_pe_f, d3_score;
  logic [7:0]    d3_pass_idx;
  logic [2:0]    d3_dbg;

  // observed outputs of the instance under test (sel: 0 -> NUM_PASS=1, 1 -> NUM_PASS=3)
  logic          sel = 1'b0;
  logic          o_host_ready, o_pe_valid, o_done, o_err;
  logic [1:0]    o_pe_t;
  logic [DW-1:0] o_pe_max, o_pe_v, o_pe_f, o_score;
  logic [7:0]    o_pass_idx;
  logic [2:0]    o_dbg;

  int n_vec = 0;
  int n_err = 0;

  logic [1:0]    seg_t [T_LEN];
  logic [DW-1:0] seg_m [T_LEN];
  logic [DW-1:0] seg_v [T_LEN];
  logic [DW-1:0] seg_f [T_LEN];

  sw_loop_ctrl #(.T_LEN(T_LEN), .NUM_PASS(1), .DW(DW)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .host_t(host_t), .host_valid(host_valid),
    .host_ready(d1_host_ready), .sr_valid(sr_valid), .sr_t(sr_t), .sr_max(sr_max),
    .sr_v(sr_v), .sr_f(sr_f), .pe_valid(d1_pe_valid), .pe_t(d1_pe_t), .pe_max(d1_pe_max),
    .pe_v(d1_pe_v), .pe_f(d1_pe_f), .pass_idx(d1_pass_idx), .score(d1_score),
    .done(d1_done), .err(d1_err), .dbg_state(d1_dbg)
  );

  sw_loop_ctrl #(.T_LEN(T_LEN), .NUM_PASS(3), .DW(DW)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .host_t(host_t), .host_valid(host_valid),
    .host_ready(d3_host_ready), .sr_valid(sr_valid), .sr_t(sr_t), .sr_max(sr_max),
    .sr_v(sr_v), .sr_f(sr_f), .pe_valid(d3_pe_valid), .pe_t(d3_pe_t), .pe_max(d3_pe_max),
    .pe_v(d3_pe_v), .pe_f(d3_pe_f), .pass_idx(d3_pass_idx), .score(d3_score),
    .done(d3_done), .err(d3_err), .dbg_state(d3_dbg)
  );

  // clock
  always #5 clk = ~clk;

  // select the instance under test
  always_comb begin
    o_host_ready = sel ? d3_host_ready : d1_host_ready;
    o_pe_valid   = sel ? d3_pe_valid   : d1_pe_valid;
    o_pe_t       = sel ? d3_pe_t       : d1_pe_t;
    o_pe_max     = sel ? d3_pe_max     : d1_pe_max;
    o_pe_v       = sel ? d3_pe_v       : d1_pe_v;
    o_pe_f       = sel ? d3_pe_f       : d1_pe_f;
    o_pass_idx   = sel ? d3_pass_idx   : d1_pass_idx;
    o_score      = sel ? d3_score      : d1_score;
    o_done       = sel ? d3_done       : d1_done;
    o_err        = sel ? d3_err        : d1_err;
    o_dbg        = sel ? d3_dbg        : d1_dbg;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse_start();
    if (sel) start3 = 1'b1;
    else     start1 = 1'b1;
    tick();
    start1 = 1'b0;
    start3 = 1'b0;
    chk("start_host_ready", o_host_ready, 1);
    chk("start_pass_idx", o_pass_idx, 0);
    chk("start_err_clear", o_err, 0);
    chk("start_score_clear", o_score, 0);
  endtask

  // one accepted host beat; the PE head shows it one cycle later with zero scores
  task automatic feed_beat(input logic [1:0] t);
    host_valid = 1'b1;
    host_t     = t;
    chk("feed_host_ready", o_host_ready, 1);
    tick();
    host_valid = 1'b0;
    chk("feed_pe_valid", o_pe_valid, 1);
    chk("feed_pe_t", o_pe_t, t);
    chk("feed_pe_max", o_pe_max, 0);
    chk("feed_pe_v", o_pe_v, 0);
    chk("feed_pe_f", o_pe_f, 0);
  endtask

  task automatic feed_all();
    for (int i = 0; i < T_LEN; i++) feed_beat(2'($urandom_range(0, 3)));
    chk("feed_done_pass_idx", o_pass_idx, 1);
  endtask

  task automatic fill_seg(input int max_hi);
    for (int i = 0; i < T_LEN; i++) begin
      seg_t[i] = 2'($urandom_range(0, 3));
      seg_m[i] = DW'($urandom_range(0, max_hi));
      seg_v[i] = DW'($urandom_range(0, 4095));
      seg_f[i] = DW'($urandom_range(0, 4095));
    end
  endtask

  task automatic seg_beat(input int i, input bit drain);
    sr_valid = 1'b1;
    sr_t     = seg_t[i];
    sr_max   = seg_m[i];
    sr_v     = seg_v[i];
    sr_f     = seg_f[i];
    tick();
    sr_valid = 1'b0;
    if (drain) begin
      chk("drain_pe_valid", o_pe_valid, 0);
    end else begin
      chk("loop_pe_valid", o_pe_valid, 1);
      chk("loop_pe_t", o_pe_t, seg_t[i]);
      chk("loop_pe_max", o_pe_max, seg_m[i]);
      chk("loop_pe_v", o_pe_v, seg_v[i]);
      chk("loop_pe_f", o_pe_f, seg_f[i]);
    end
  endtask

  // full segment after a random WAIT gap; a drain segment ends with done and the max
  task automatic run_seg(input bit drain, input logic [7:0] exp_pass);
    logic [DW-1:0] ref_max;
    int gap;
    gap = $urandom_range(0, 2);
    for (int g = 0; g < gap; g++) begin
      tick();
      chk("wait_pe_valid", o_pe_valid, 0);
    end
    for (int i = 0; i < T_LEN; i++) seg_beat(i, drain);
    chk("seg_pass_idx", o_pass_idx, exp_pass);
    if (drain) begin
      ref_max = '0;
      for (int i = 0; i < T_LEN; i++) if (seg_m[i] > ref_max) ref_max = seg_m[i];
      chk("done_pulse", o_done, 1);
      chk("final_score", o_score, ref_max);
      tick();
      chk("done_one_cycle", o_done, 0);
      chk("score_hold", o_score, ref_max);
    end else begin
      chk("loop_no_done", o_done, 0);
    end
  endtask

  // safety net in case the directed flow ever stalls
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, run did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state of both instances
    tick();
    chk("rst_pe_valid1", d1_pe_valid, 0);
    chk("rst_host_ready1", d1_host_ready, 0);
    chk("rst_done1", d1_done, 0);
    chk("rst_pe_valid3", d3_pe_valid, 0);
    chk("rst_pass_idx3", d3_pass_idx, 0);
    chk("rst_score3", d3_score, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("idle_host_ready", o_host_ready, 0);

    // single pass: host 0..3, then drain 5,9,3,7
    sel = 1'b0;
    pulse_start();
    feed_beat(2'd0); feed_beat(2'd1); feed_beat(2'd2); feed_beat(2'd3);
    chk("s1_pass_idx", o_pass_idx, 1);
    fill_seg(4095);
    seg_m[0] = 12'd5; seg_m[1] = 12'd9; seg_m[2] = 12'd3; seg_m[3] = 12'd7;
    run_seg(1'b1, 8'd1);
    chk("s1_score_9", o_score, 9);
    chk("s1_err", o_err, 0);

    // host bubble after beat 2 of 4
    pulse_start();
    feed_beat(2'd3); feed_beat(2'd2);
    host_valid = 1'b0;
    tick();
    chk("bubble_err", o_err, 1);
    chk("bubble_pe_valid", o_pe_valid, 0);
    chk("bubble_pass_idx", o_pass_idx, 0);
    feed_beat(2'd1); feed_beat(2'd0);
    chk("bubble_pass_idx_after", o_pass_idx, 1);
    fill_seg(4095);
    run_seg(1'b1, 8'd1);
    chk("bubble_err_sticky", o_err, 1);

    // short segment in LOOP, then reset in the middle of the next LOOP pass
    sel = 1'b1;
    pulse_start();
    feed_all();
    fill_seg(4095);
    seg_beat(0, 1'b0); seg_beat(1, 1'b0); seg_beat(2, 1'b0);
    tick();
    chk("short_err", o_err, 1);
    chk("short_pe_valid", o_pe_valid, 0);
    chk("short_pass_idx", o_pass_idx, 1);
    seg_beat(3, 1'b0);
    chk("short_complete_pass_idx", o_pass_idx, 2);
    fill_seg(4095);
    seg_beat(0, 1'b0); seg_beat(1, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("arst_pe_valid", o_pe_valid, 0);
    chk("arst_pe_max", o_pe_max, 0);
    chk("arst_pass_idx", o_pass_idx, 0);
    chk("arst_err", o_err, 0);
    chk("arst_state_idle", o_dbg, 0);
    tick();
    rst = 1'b0;
    tick();

    // clean recirculating run: pass_idx 0,1,2,3 and a reduced third segment
    pulse_start();
    feed_all();
    fill_seg(4095);
    run_seg(1'b0, 8'd2);
    fill_seg(4095);
    run_seg(1'b0, 8'd3);
    fill_seg(4095);
    run_seg(1'b1, 8'd3);
    chk("recirc_err", o_err, 0);

    // start ignored during FEED; saturated max in DRAIN
    sel = 1'b0;
    pulse_start();
    feed_beat(2'd1);
    start1 = 1'b1;
    feed_beat(2'd2);
    start1 = 1'b0;
    feed_beat(2'd3); feed_beat(2'd0);
    chk("ign_start_pass_idx", o_pass_idx, 1);
    fill_seg(4000);
    seg_m[2] = 12'd4095;
    run_seg(1'b1, 8'd1);
    chk("sat_score", o_score, 4095);

    // second run: score cleared by start, sr_valid during FEED flags err
    pulse_start();
    feed_beat(2'd2);
    sr_valid = 1'b1;
    feed_beat(2'd1);
    sr_valid = 1'b0;
    chk("sr_in_feed_err", o_err, 1);
    feed_beat(2'd0); feed_beat(2'd3);
    fill_seg(4094);
    run_seg(1'b1, 8'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
